// File: rtl/uart_piso.sv
// rtl/uart_piso.sv - parallel-in serial-out UART transmitter clocked at the bit rate
module uart_piso #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  baud_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_tx,
    output logic                  send,
    output logic                  data_tx,
    output logic                  tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic             ODD_BIT   = 1'(PARITY_ODD);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    parity_q, parity_d;
    logic                    send_q, send_d;
    logic                    line_q, line_d;
    logic                    done_q, done_d;

    // Next-state logic computes the registered output values one cycle ahead,
    // so each output bit appears exactly on the edge that enters its state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        send_d   = send_q;
        line_d   = line_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                send_d = 1'b0;
                line_d = 1'b1;
                if (valid_tx) begin
                    shift_d  = data_in;
                    parity_d = (^data_in) ^ ODD_BIT;
                    cnt_d    = '0;
                    state_d  = S_START;
                    send_d   = 1'b1;
                    line_d   = 1'b0;
                end
            end
            S_START: begin
                line_d  = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d = S_PARITY;
                        line_d  = parity_q;
                    end else begin
                        state_d = S_STOP;
                        line_d  = 1'b1;
                    end
                end else begin
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
                line_d  = 1'b1;
                cnt_d   = '0;
            end
            S_STOP: begin
                line_d = 1'b1;
                if (cnt_q == LAST_STOP) begin
                    state_d = S_IDLE;
                    send_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                send_d  = 1'b0;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            send_q   <= 1'b0;
            line_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            send_q   <= send_d;
            line_q   <= line_d;
            done_q   <= done_d;
        end
    end

    assign send    = send_q;
    assign data_tx = line_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_piso.sv
// tb/tb_uart_piso.sv - randomized frame-level check of uart_piso in three configurations
module tb_uart_piso;

    logic       baud_clk = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       valid_tx = 1'b0;
    logic [2:0] line_w, send_w, done_w;

    int checks = 0;
    int errors = 0;

    // Configurations: 0 = 8N1, 1 = 8E1, 2 = 8O2
    int        cfg_pe [3] = '{0, 1, 1};
    int        cfg_po [3] = '{0, 0, 1};
    int        cfg_sb [3] = '{1, 1, 2};
    bit        m_act  [3];
    int        m_pos  [3];
    logic [7:0] m_word[3];

    always #5 baud_clk = ~baud_clk;

    uart_piso #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .baud_clk(baud_clk), .rst(rst), .data_in(data_in), .valid_tx(valid_tx),
        .send(send_w[0]), .data_tx(line_w[0]), .tx_done(done_w[0]));

    uart_piso #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .baud_clk(baud_clk), .rst(rst), .data_in(data_in), .valid_tx(valid_tx),
        .send(send_w[1]), .data_tx(line_w[1]), .tx_done(done_w[1]));

    uart_piso #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
        .baud_clk(baud_clk), .rst(rst), .data_in(data_in), .valid_tx(valid_tx),
        .send(send_w[2]), .data_tx(line_w[2]), .tx_done(done_w[2]));

    function automatic int frame_len(input int i);
        return 1 + 8 + cfg_pe[i] + cfg_sb[i];
    endfunction

    // Expected line level from the frame layout: start, LSB-first data, parity, stops.
    function automatic logic exp_line(input int i);
        int p;
        p = m_pos[i];
        if (!m_act[i] || p >= frame_len(i)) return 1'b1;
        if (p == 0) return 1'b0;
        if (p <= 8) return m_word[i][p-1];
        if (cfg_pe[i] != 0 && p == 9) return (^m_word[i]) ^ (cfg_po[i] != 0);
        return 1'b1;
    endfunction

    function automatic logic exp_send(input int i);
        return m_act[i] && m_pos[i] < frame_len(i);
    endfunction

    function automatic logic exp_done(input int i);
        return m_act[i] && m_pos[i] == frame_len(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0;
            m_pos[i] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            if ((!m_act[i] || m_pos[i] >= frame_len(i)) && v) begin
                m_act[i]  = 1'b1;
                m_pos[i]  = 0;
                m_word[i] = d;
            end else if (m_act[i] && m_pos[i] <= frame_len(i)) begin
                m_pos[i] = m_pos[i] + 1;
            end
        end
    endtask

    task automatic check(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, i, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check("data_tx", i, line_w[i], exp_line(i));
            check("send",    i, send_w[i], exp_send(i));
            check("tx_done", i, done_w[i], exp_done(i));
            check("send_and_done_excl", i, send_w[i] & done_w[i], 1'b0);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        valid_tx = v;
        data_in  = d;
        @(posedge baud_clk);
        if (rst) model_step(v, d);
        @(negedge baud_clk);
        compare_all();
    endtask

    task automatic frame(input logic [7:0] d, input int idle_after);
        cycle(1'b1, d);
        for (int c = 0; c < idle_after; c++) cycle(1'b0, 8'($urandom));
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        @(negedge baud_clk);
        for (int c = 0; c < 4; c++) cycle(1'b1, 8'($urandom));
        rst = 1'b1;
        for (int c = 0; c < 3; c++) cycle(1'b0, 8'($urandom));

        frame(8'h54, 14);
        frame(8'hA3, 14);
        frame(8'hFF, 14);
        frame(8'h00, 14);

        // A second request mid-frame must be ignored by every configuration.
        cycle(1'b1, 8'h54);
        for (int c = 0; c < 3; c++) cycle(1'b0, 8'h54);
        cycle(1'b1, 8'h00);
        for (int c = 0; c < 12; c++) cycle(1'b0, 8'h00);

        // Asynchronous reset while data bit 3 is on the line.
        cycle(1'b1, 8'h54);
        for (int c = 0; c < 4; c++) cycle(1'b0, 8'hFF);
        rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check("rst_line", i, line_w[i], 1'b1);
            check("rst_send", i, send_w[i], 1'b0);
            check("rst_done", i, done_w[i], 1'b0);
        end
        @(negedge baud_clk);
        for (int c = 0; c < 2; c++) cycle(1'b0, 8'h00);
        rst = 1'b1;
        frame(8'hC5, 14);

        // Continuous request: each frame re-samples data_in at its own accept edge.
        for (int c = 0; c < 60; c++) cycle(1'b1, 8'($urandom));
        for (int c = 0; c < 14; c++) cycle(1'b0, 8'h00);

        for (int c = 0; c < 400; c++) cycle(($urandom_range(0, 3) == 0), 8'($urandom));
        for (int c = 0; c < 14; c++) cycle(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
